// File: rtl/mult_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_share_arb_pkg
// Shared types and constants for the two-requester multiply-cell arbiter.
// No ports. Used by mult_share_arb_if, mult_share_arb_rsp_fifo and mult_share_arb.
// -----------------------------------------------------------------------------
package mult_share_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;

    // Requester index carried alongside each operation in the cell pipeline.
    typedef logic req_id_t;

    // One cell pipeline stage: valid flag plus owning requester.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

    // True when a stage holds a live operation owned by requester r.
    function automatic logic tag_hits(input tag_t t, input int unsigned r);
        return t.vld && (t.id == req_id_t'(r));
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// -----------------------------------------------------------------------------
// mult_share_arb_if
// Bundles both requester request/response channels and the multiply-cell
// operand/result signals.
//   slave  : arbiter side (drives req*_ready, rsp*_valid/result, cell_src*)
//   master : requester/cell side (drives req*_valid/src*, rsp*_ready, cell_result)
// -----------------------------------------------------------------------------
interface mult_share_arb_if
    import mult_share_arb_pkg::*;
();

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_src1;
    logic [DATA_W-1:0] req0_src2;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_result;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_src1;
    logic [DATA_W-1:0] req1_src2;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_result;

    logic [DATA_W-1:0] cell_src1;
    logic [DATA_W-1:0] cell_src2;
    logic [DATA_W-1:0] cell_result;

    modport slave (
        input  req0_valid, req0_src1, req0_src2, rsp0_ready,
        input  req1_valid, req1_src1, req1_src2, rsp1_ready,
        input  cell_result,
        output req0_ready, rsp0_valid, rsp0_result,
        output req1_ready, rsp1_valid, rsp1_result,
        output cell_src1, cell_src2
    );

    modport master (
        output req0_valid, req0_src1, req0_src2, rsp0_ready,
        output req1_valid, req1_src1, req1_src2, rsp1_ready,
        output cell_result,
        input  req0_ready, rsp0_valid, rsp0_result,
        input  req1_ready, rsp1_valid, rsp1_result,
        input  cell_src1, cell_src2
    );

endinterface

// File: rtl/mult_share_arb_rsp_fifo.sv
// -----------------------------------------------------------------------------
// mult_share_arb_rsp_fifo
// Per-requester response FIFO. Head is presented directly on rd_data.
//   clk, reset_n : clock, async active-low reset (flushes contents)
//   wr_en/wr_data: push a cell result
//   rd_ready     : consumer pops head when rd_valid
//   rd_valid     : FIFO not empty
//   rd_data      : FIFO head (zero after reset)
//   count        : current occupancy, used for credit accounting
// -----------------------------------------------------------------------------
module mult_share_arb_rsp_fifo
    import mult_share_arb_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             wr_en,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             rd_ready,
    output logic                             rd_valid,
    output logic [DATA_W-1:0]                rd_data,
    output logic [$clog2(RSP_DEPTH + 1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    // Credit accounting upstream must make overflow impossible.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(wr_en && !pop && (count_q == CNT_W'(RSP_DEPTH))))
                else $error("mult_share_arb_rsp_fifo: write into full FIFO");
        end
    end
`endif

endmodule

// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
// Shares one pipelined 32-bit low-word multiply cell between two requesters
// (requester 0: CPU custom-instruction path, requester 1: motor-control PID).
// Issues at most one operation per cycle, tags it through the cell pipeline
// and returns the product to the owner's response FIFO. An operation is only
// issued when its owner has a guaranteed FIFO slot (credit).
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : mult_share_arb_if.slave -- req*/rsp* channels and cell operands
// Parameters: CELL_LATENCY (1..4) cell edges, RSP_DEPTH (2..8) FIFO entries.
// Build option: define MULT_ARB_FIXED_PRIO_EN for strict priority to
// requester 0; otherwise round-robin.
// -----------------------------------------------------------------------------
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int unsigned CELL_LATENCY = 1,
    parameter int unsigned RSP_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_share_arb_if.slave bus
);

    localparam int unsigned FCNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(RSP_DEPTH + CELL_LATENCY + 1) + 1;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] wr_en;
    logic [NUM_REQ-1:0] elig;
    logic [DATA_W-1:0]  req_src1 [NUM_REQ];
    logic [DATA_W-1:0]  req_src2 [NUM_REQ];
    logic [FCNT_W-1:0]  fifo_count [NUM_REQ];
    logic [OCC_W-1:0]   inflight [NUM_REQ];
    logic [OCC_W-1:0]   occ [NUM_REQ];

    logic               grant_vld;
    req_id_t            grant_id;
    tag_t               issue_tag;
    tag_t               tag_q [CELL_LATENCY];
    tag_t               tag_out;
    logic [DATA_W-1:0]  cell_src1_q;
    logic [DATA_W-1:0]  cell_src2_q;

    // Flatten the interface into per-requester arrays.
    assign req_valid[0] = bus.req0_valid;
    assign req_valid[1] = bus.req1_valid;
    assign req_src1[0]  = bus.req0_src1;
    assign req_src1[1]  = bus.req1_src1;
    assign req_src2[0]  = bus.req0_src2;
    assign req_src2[1]  = bus.req1_src2;
    assign rsp_ready[0] = bus.rsp0_ready;
    assign rsp_ready[1] = bus.rsp1_ready;

    assign pop = rsp_valid & rsp_ready;

    // Occupancy = in-flight ops + queued results; a pop this cycle returns
    // its slot immediately so a single requester can issue every cycle.
    // Gating with reset_n keeps req*_ready low while reset is held.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            inflight[r] = '0;
            for (int unsigned s = 0; s < CELL_LATENCY; s++) begin
                if (tag_hits(tag_q[s], r)) begin
                    inflight[r] = inflight[r] + OCC_W'(1);
                end
            end
            occ[r]  = inflight[r] + OCC_W'(fifo_count[r]) - OCC_W'(pop[r]);
            elig[r] = reset_n && req_valid[r] && (occ[r] < OCC_W'(RSP_DEPTH));
        end
    end

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Strict priority: requester 0 wins whenever eligible.
    always_comb begin
        grant_vld = |elig;
        grant_id  = req_id_t'(~elig[0]);
    end
`else
    req_id_t last_q;

    // Round-robin: on contention grant the requester not granted last.
    always_comb begin
        grant_vld = |elig;
        grant_id  = '0;
        if (elig[0] && elig[1]) begin
            grant_id = ~last_q;
        end else if (elig[1]) begin
            grant_id = 1'b1;
        end
    end

    // last_q resets to 1 so requester 0 wins the first contest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (grant_vld) begin
            last_q <= grant_id;
        end
    end
`endif

    assign bus.req0_ready = grant_vld && (grant_id == 1'b0);
    assign bus.req1_ready = grant_vld && (grant_id == 1'b1);

    // Operands follow the grant; held at last issued values when idle.
    assign bus.cell_src1 = grant_vld ? req_src1[grant_id] : cell_src1_q;
    assign bus.cell_src2 = grant_vld ? req_src2[grant_id] : cell_src2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_src1_q <= '0;
            cell_src2_q <= '0;
        end else if (grant_vld) begin
            cell_src1_q <= req_src1[grant_id];
            cell_src2_q <= req_src2[grant_id];
        end
    end

    // Tag pipeline mirrors the cell latency; stage-out marks cell_result valid.
    assign issue_tag = '{vld: grant_vld, id: grant_id};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < CELL_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= issue_tag;
            for (int unsigned s = 1; s < CELL_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_out  = tag_q[CELL_LATENCY-1];
    assign wr_en[0] = tag_hits(tag_out, 0);
    assign wr_en[1] = tag_hits(tag_out, 1);

    mult_share_arb_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en[0]),
        .wr_data  (bus.cell_result),
        .rd_ready (rsp_ready[0]),
        .rd_valid (rsp_valid[0]),
        .rd_data  (bus.rsp0_result),
        .count    (fifo_count[0])
    );

    mult_share_arb_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en[1]),
        .wr_data  (bus.cell_result),
        .rd_ready (rsp_ready[1]),
        .rd_valid (rsp_valid[1]),
        .rd_data  (bus.rsp1_result),
        .count    (fifo_count[1])
    );

    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];

endmodule

// File: tb/tb_mult_share_arb.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arb
// Directed bench for mult_share_arb with a one-edge model multiply cell.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
// after it. Expectations follow the build option MULT_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_mult_share_arb;
    import mult_share_arb_pkg::*;

    localparam int unsigned CELL_LATENCY = 1;
    localparam int unsigned RSP_DEPTH    = 2;
`ifdef MULT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   acc0;
    int   acc1;
    logic exp0;

    mult_share_arb_if bus ();

    mult_share_arb #(
        .CELL_LATENCY (CELL_LATENCY),
        .RSP_DEPTH    (RSP_DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model cell: registered low-word product, one edge of latency.
    always @(posedge clk) bus.cell_result <= bus.cell_src1 * bus.cell_src2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Requests held valid through reset: ready must stay low anyway.
        bus.req0_valid = 1'b1; bus.req0_src1 = 32'd2; bus.req0_src2 = 32'd3;
        bus.req1_valid = 1'b1; bus.req1_src1 = 32'd7; bus.req1_src2 = 32'd11;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check1("rst_req0_ready", bus.req0_ready, 1'b0);
        check1("rst_req1_ready", bus.req1_ready, 1'b0);
        check1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        check1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        check("rst_rsp0_result", bus.rsp0_result, 32'h0);
        check("rst_rsp1_result", bus.rsp1_result, 32'h0);
        check("rst_cell_src1", bus.cell_src1, 32'h0);
        check("rst_cell_src2", bus.cell_src2, 32'h0);

        // Contention from reset: RR alternates 0,1,0,1; fixed priority always 0.
        @(posedge clk); #1; reset_n = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                @(posedge clk); #2;
            end
            exp0 = FIXED ? 1'b1 : ((k % 2) == 0);
            check1($sformatf("cont%0d_req0_ready", k), bus.req0_ready, exp0);
            check1($sformatf("cont%0d_req1_ready", k), bus.req1_ready, ~exp0);
            check($sformatf("cont%0d_cell_src1", k), bus.cell_src1, exp0 ? 32'd2 : 32'd7);
            if (k == 2) begin
                check1("cont2_rsp0_valid", bus.rsp0_valid, 1'b1);
                check("cont2_rsp0_result", bus.rsp0_result, 32'd6);
            end
            if (k == 3) begin
                check1("cont3_rsp1_valid", bus.rsp1_valid, ~FIXED);
                check("cont3_rsp1_result", bus.rsp1_result, FIXED ? 32'd0 : 32'd77);
            end
        end
        @(posedge clk); #1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check1("drain_rsp0_valid", bus.rsp0_valid, 1'b0);
        check1("drain_rsp1_valid", bus.rsp1_valid, 1'b0);

        // Single op 3x5: ready in accept cycle, response two cycles later.
        @(posedge clk); #1; bus.req0_valid = 1'b1; bus.req0_src1 = 32'd3; bus.req0_src2 = 32'd5; #1;
        check1("single_req0_ready", bus.req0_ready, 1'b1);
        check("single_cell_src1", bus.cell_src1, 32'd3);
        check("single_cell_src2", bus.cell_src2, 32'd5);
        check1("single_rsp0_valid_n", bus.rsp0_valid, 1'b0);
        @(posedge clk); #1; bus.req0_valid = 1'b0; #1;
        check1("single1_req0_ready", bus.req0_ready, 1'b0);
        check("single1_cell_src1_hold", bus.cell_src1, 32'd3);
        check("single1_cell_src2_hold", bus.cell_src2, 32'd5);
        check1("single1_rsp0_valid", bus.rsp0_valid, 1'b0);
        @(posedge clk); #2;
        check1("single2_rsp0_valid", bus.rsp0_valid, 1'b1);
        check("single2_rsp0_result", bus.rsp0_result, 32'd15);
        @(posedge clk); #2;
        check1("single3_rsp0_valid", bus.rsp0_valid, 1'b0);

        // Wrap cases with rsp0 stalled; third request blocked by credit.
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0; bus.req0_valid = 1'b1;
        bus.req0_src1 = 32'hFFFF_FFFF; bus.req0_src2 = 32'hFFFF_FFFF; #1;
        check1("wrap0_req0_ready", bus.req0_ready, 1'b1);
        @(posedge clk); #1; bus.req0_src1 = 32'h0001_0000; bus.req0_src2 = 32'h0001_0000; #1;
        check1("wrap1_req0_ready", bus.req0_ready, 1'b1);
        @(posedge clk); #1; bus.req0_src1 = 32'd1; bus.req0_src2 = 32'd1; #1;
        check1("wrap2_req0_ready_nocredit", bus.req0_ready, 1'b0);
        check1("wrap2_rsp0_valid", bus.rsp0_valid, 1'b1);
        check("wrap2_rsp0_result", bus.rsp0_result, 32'h0000_0001);
        @(posedge clk); #1; bus.req0_valid = 1'b0; bus.rsp0_ready = 1'b1; #1;
        check("wrap3_rsp0_result", bus.rsp0_result, 32'h0000_0001);
        @(posedge clk); #2;
        check1("wrap4_rsp0_valid", bus.rsp0_valid, 1'b1);
        check("wrap4_rsp0_result", bus.rsp0_result, 32'h0000_0000);
        @(posedge clk); #2;
        check1("wrap5_rsp0_valid", bus.rsp0_valid, 1'b0);

        // Backpressure on requester 1: exactly two accepts, then stall.
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b0; bus.req1_valid = 1'b1;
        bus.req1_src1 = 32'd4; bus.req1_src2 = 32'd6; #1;
        check1("bp0_req1_ready", bus.req1_ready, 1'b1);
        @(posedge clk); #1; bus.req1_src1 = 32'd9; bus.req1_src2 = 32'd9; #1;
        check1("bp1_req1_ready", bus.req1_ready, 1'b1);
        @(posedge clk); #1; bus.req1_src1 = 32'd100; bus.req1_src2 = 32'd100; #1;
        check1("bp2_req1_ready", bus.req1_ready, 1'b0);
        check1("bp2_rsp1_valid", bus.rsp1_valid, 1'b1);
        check("bp2_rsp1_result", bus.rsp1_result, 32'd24);
        @(posedge clk); #2;
        check1("bp3_req1_ready", bus.req1_ready, 1'b0);
        // Requester 0 keeps issuing every cycle while requester 1 is stalled.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.req0_valid = 1'b1; bus.req0_src1 = 32'd3; bus.req0_src2 = 32'd5; #1;
            check1($sformatf("bp_r0_%0d_req0_ready", k), bus.req0_ready, 1'b1);
            check1($sformatf("bp_r0_%0d_req1_ready", k), bus.req1_ready, 1'b0);
        end

        // Release: one pop frees one slot, granted in the same cycle.
        @(posedge clk); #1; bus.req0_valid = 1'b0; bus.rsp1_ready = 1'b1; #1;
        check1("rel0_req1_ready", bus.req1_ready, 1'b1);
        check("rel0_rsp1_result", bus.rsp1_result, 32'd24);
        @(posedge clk); #1; bus.rsp1_ready = 1'b0; #1;
        check1("rel1_req1_ready", bus.req1_ready, 1'b0);
        check1("rel1_rsp1_valid", bus.rsp1_valid, 1'b1);
        check("rel1_rsp1_result", bus.rsp1_result, 32'd81);
        @(posedge clk); #2;
        check1("rel2_req1_ready", bus.req1_ready, 1'b0);
        @(posedge clk); #1; bus.req1_valid = 1'b0; bus.rsp1_ready = 1'b1; #1;
        check("rel3_rsp1_result", bus.rsp1_result, 32'd81);
        @(posedge clk); #2;
        check1("rel4_rsp1_valid", bus.rsp1_valid, 1'b1);
        check("rel4_rsp1_result", bus.rsp1_result, 32'd10000);
        @(posedge clk); #2;
        check1("rel5_rsp1_valid", bus.rsp1_valid, 1'b0);

        // Reset one cycle after accepting two ops: everything discarded.
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_src1 = 32'd5; bus.req0_src2 = 32'd5; #1;
        check1("mf0_req0_ready", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b1;
        bus.req1_src1 = 32'd6; bus.req1_src2 = 32'd6; #1;
        check1("mf1_req1_ready", bus.req1_ready, 1'b1);
        @(posedge clk); #1; bus.req1_valid = 1'b0; reset_n = 1'b0; #1;
        check1("mf_rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        check("mf_rst_rsp0_result", bus.rsp0_result, 32'h0);
        check("mf_rst_cell_src1", bus.cell_src1, 32'h0);
        @(posedge clk); #1; reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check1($sformatf("mf_post%0d_rsp0_valid", k), bus.rsp0_valid, 1'b0);
            check1($sformatf("mf_post%0d_rsp1_valid", k), bus.rsp1_valid, 1'b0);
        end

        // Full credits restored: two accepts per requester with responses stalled.
        acc0 = 0;
        acc1 = 0;
        @(posedge clk); #1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; #1;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) begin
                @(posedge clk); #2;
            end
            acc0 += int'(bus.req0_ready);
            acc1 += int'(bus.req1_ready);
        end
        check("credit_req0_accepts", 32'(acc0), 32'd2);
        check("credit_req1_accepts", 32'(acc1), 32'd2);
        @(posedge clk); #1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
